// File: rtl/op_exec_unit.sv
// op_exec_unit: element-serial matrix operation engine.
// Reads operands through the storage port, writes results one element at a time.
module op_exec_unit #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_op,
  input  logic [2:0]        op_sel,
  input  logic [DATA_W-1:0] scalar_val,
  input  logic [2:0]        a_rows,
  input  logic [2:0]        a_cols,
  input  logic [2:0]        b_rows,
  input  logic [2:0]        b_cols,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [2:0]        rd_row,
  output logic [2:0]        rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [2:0]        wr_row,
  output logic [2:0]        wr_col,
  output logic [ACC_W-1:0]  wr_data,
  output logic [2:0]        res_rows,
  output logic [2:0]        res_cols,
  output logic              busy_flag,
  output logic              done_flag,
  output logic              error_flag,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD_A, RD_B, MAC, WR, DONE, ERR
  } state_t;

  localparam logic [2:0] OP_T = 3'd0;
  localparam logic [2:0] OP_A = 3'd1;
  localparam logic [2:0] OP_B = 3'd2;
  localparam logic [2:0] OP_C = 3'd3;
  localparam logic [2:0] OP_J = 3'd4;
  localparam logic [2:0] MAXD = 3'(MAX_DIM);

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [DATA_W-1:0] scal_q;
  logic [2:0]        ar_q, ac_q, br_q, bc_q;
  logic [2:0]        i_q, j_q, k_q;
  logic [1:0]        u_q, v_q;
  logic [DATA_W-1:0] a_reg;
  logic [ACC_W-1:0]  acc;
  logic [2:0]        rd_row_q, rd_col_q;

  logic              uses_b;
  logic              mism;
  logic              bad_a, bad_b;
  logic [1:0]        chk_err;
  logic [2:0]        res_r_nxt, res_c_nxt;
  logic              term_first, term_last;
  logic              elem_last;
  logic [2:0]        addr_row, addr_col;
  logic [ACC_W-1:0]  prod, base, acc_nxt;

  function automatic logic dim_bad(input logic [2:0] d);
    return (d == 3'd0) || (d > MAXD);
  endfunction

  assign uses_b = (op_q == OP_A) || (op_q == OP_C) || (op_q == OP_J);
  assign bad_a  = dim_bad(ar_q) || dim_bad(ac_q);
  assign bad_b  = dim_bad(br_q) || dim_bad(bc_q);

  // Operand validation in priority order: opcode, range, shape.
  always_comb begin
    mism    = 1'b0;
    chk_err = 2'b00;
    unique case (1'b1)
      op_q == OP_A: mism = (ar_q != br_q) || (ac_q != bc_q);
      op_q == OP_C: mism = (ac_q != br_q);
      op_q == OP_J: mism = (br_q != 3'd3) || (bc_q != 3'd3)
                        || (ar_q < 3'd3) || (ac_q < 3'd3);
      default:      mism = 1'b0;
    endcase
    if (op_q > OP_J) begin
      chk_err = 2'b01;
    end else if (bad_a || (uses_b && bad_b)) begin
      chk_err = 2'b10;
    end else if (mism) begin
      chk_err = 2'b11;
    end
  end

  // Result shape for the accepted op.
  always_comb begin
    res_r_nxt = ar_q;
    res_c_nxt = ac_q;
    case (op_q)
      OP_T: begin
        res_r_nxt = ac_q;
        res_c_nxt = ar_q;
      end
      OP_C: res_c_nxt = bc_q;
      OP_J: begin
        res_r_nxt = ar_q - 3'd2;
        res_c_nxt = ac_q - 3'd2;
      end
      default: ;
    endcase
  end

  // Term bookkeeping: first term clears acc, last term leaves for WR.
  always_comb begin
    term_first = 1'b1;
    term_last  = 1'b1;
    if (op_q == OP_C) begin
      term_first = (k_q == 3'd0);
      term_last  = (k_q == ac_q - 3'd1);
    end else if (op_q == OP_J) begin
      term_first = (u_q == 2'd0) && (v_q == 2'd0);
      term_last  = (u_q == 2'd2) && (v_q == 2'd2);
    end
  end

  assign elem_last = (i_q == res_rows - 3'd1)
                  && (j_q == res_cols - 3'd1);

  // Read coordinates for the A and B fetch cycles.
  always_comb begin
    addr_row = rd_row_q;
    addr_col = rd_col_q;
    if (state_q == RD_A) begin
      case (op_q)
        OP_T: begin
          addr_row = j_q;
          addr_col = i_q;
        end
        OP_A, OP_B: begin
          addr_row = i_q;
          addr_col = j_q;
        end
        OP_C: begin
          addr_row = i_q;
          addr_col = k_q;
        end
        OP_J: begin
          addr_row = i_q + {1'b0, u_q};
          addr_col = j_q + {1'b0, v_q};
        end
        default: ;
      endcase
    end else if (state_q == RD_B) begin
      case (op_q)
        OP_A: begin
          addr_row = i_q;
          addr_col = j_q;
        end
        OP_C: begin
          addr_row = k_q;
          addr_col = j_q;
        end
        OP_J: begin
          addr_row = {1'b0, u_q};
          addr_col = {1'b0, v_q};
        end
        default: ;
      endcase
    end
  end

  // Accumulator update; B operand is taken straight off the read port.
  always_comb begin
    prod    = ACC_W'(a_reg) * ACC_W'(rd_data);
    base    = term_first ? '0 : acc;
    acc_nxt = acc;
    case (op_q)
      OP_T:    acc_nxt = ACC_W'(a_reg);
      OP_A:    acc_nxt = ACC_W'(a_reg) + ACC_W'(rd_data);
      OP_B:    acc_nxt = ACC_W'(a_reg) * ACC_W'(scal_q);
      default: acc_nxt = base + prod;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and read strobe decode.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_sel  = 1'b0;
    case (state_q)
      IDLE:  if (start_op) state_d = CHECK;
      CHECK: state_d = (chk_err != 2'b00) ? ERR : RD_A;
      RD_A: begin
        rd_en   = 1'b1;
        state_d = RD_B;
      end
      RD_B: begin
        rd_en   = uses_b;
        rd_sel  = uses_b;
        state_d = MAC;
      end
      MAC:   state_d = term_last ? WR : RD_A;
      WR:    state_d = elem_last ? DONE : RD_A;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_row     = rd_en ? addr_row : rd_row_q;
  assign rd_col     = rd_en ? addr_col : rd_col_q;
  assign wr_en      = (state_q == WR);
  assign wr_row     = i_q;
  assign wr_col     = j_q;
  assign wr_data    = acc;
  assign busy_flag  = (state_q != IDLE);
  assign done_flag  = (state_q == DONE);
  assign error_flag = (state_q == ERR);

  // Operand capture, loop counters and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      scal_q   <= '0;
      ar_q     <= '0;
      ac_q     <= '0;
      br_q     <= '0;
      bc_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      a_reg    <= '0;
      acc      <= '0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      res_rows <= '0;
      res_cols <= '0;
      err_code <= '0;
    end else begin
      if (rd_en) begin
        rd_row_q <= addr_row;
        rd_col_q <= addr_col;
      end
      case (state_q)
        IDLE: begin
          if (start_op) begin
            op_q     <= op_sel;
            scal_q   <= scalar_val;
            ar_q     <= a_rows;
            ac_q     <= a_cols;
            br_q     <= b_rows;
            bc_q     <= b_cols;
            err_code <= 2'b00;
          end
        end
        CHECK: begin
          if (chk_err != 2'b00) begin
            err_code <= chk_err;
          end else begin
            res_rows <= res_r_nxt;
            res_cols <= res_c_nxt;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
          end
        end
        RD_B: a_reg <= rd_data;
        MAC: begin
          acc <= acc_nxt;
          if (term_last) begin
            k_q <= '0;
            u_q <= '0;
            v_q <= '0;
          end else if (op_q == OP_C) begin
            k_q <= k_q + 3'd1;
          end else if (v_q == 2'd2) begin
            v_q <= '0;
            u_q <= u_q + 2'd1;
          end else begin
            v_q <= v_q + 2'd1;
          end
        end
        WR: begin
          if (j_q == res_cols - 3'd1) begin
            j_q <= '0;
            i_q <= i_q + 3'd1;
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_exec_unit.sv
// tb_op_exec_unit: directed tests with a matrix-level reference model.
// Storage is modelled as two 5x5 arrays with one-cycle read latency.
module tb_op_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_op;
  logic [2:0]  op_sel;
  logic [7:0]  scalar_val;
  logic [2:0]  a_rows, a_cols, b_rows, b_cols;
  logic        rd_en, rd_sel;
  logic [2:0]  rd_row, rd_col;
  logic [7:0]  rd_data = '0;
  logic        wr_en;
  logic [2:0]  wr_row, wr_col;
  logic [19:0] wr_data;
  logic [2:0]  res_rows, res_cols;
  logic        busy_flag, done_flag, error_flag;
  logic [1:0]  err_code;

  op_exec_unit #(.DATA_W(8), .ACC_W(20), .MAX_DIM(5)) dut (
    .clk(clk), .rst(rst), .start_op(start_op), .op_sel(op_sel),
    .scalar_val(scalar_val),
    .a_rows(a_rows), .a_cols(a_cols),
    .b_rows(b_rows), .b_cols(b_cols),
    .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data),
    .res_rows(res_rows), .res_cols(res_cols),
    .busy_flag(busy_flag), .done_flag(done_flag),
    .error_flag(error_flag), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [2:0]  c;
    logic [19:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  ma [5][5];
  logic [7:0]  mb [5][5];
  wr_t         exp_q[$];
  int          got_q[$];
  wr_t         e;
  int          last_done;
  int          last_dones;
  int          last_err_at;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (rd_en)
      rd_data <= rd_sel ? mb[rd_row][rd_col] : ma[rd_row][rd_col];

  task automatic chk(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Every write is checked against the model's expected sequence.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      got_q.push_back(int'(wr_data));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got (%0d,%0d)=%0d required none",
                 wr_row, wr_col, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_row !== e.r || wr_col !== e.c || wr_data !== e.d) begin
          errors++;
          $display("FAIL write got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                   wr_row, wr_col, wr_data, e.r, e.c, e.d);
        end
      end
    end
  end

  function automatic void build_model(
    input  logic [2:0] op, input logic [7:0] sc,
    input  logic [2:0] ar, input logic [2:0] ac,
    input  logic [2:0] br, input logic [2:0] bc,
    output int xend, output logic [1:0] xerr,
    output int rows, output int cols);
    bit     ub;
    int     terms;
    longint v;
    wr_t    w;
    ub    = (op == 3'd1 || op == 3'd3 || op == 3'd4);
    xerr  = 2'd0;
    rows  = 0;
    cols  = 0;
    terms = 1;
    exp_q.delete();
    if (op > 3'd4)
      xerr = 2'd1;
    else if (ar == 0 || ar > 5 || ac == 0 || ac > 5 ||
             (ub && (br == 0 || br > 5 || bc == 0 || bc > 5)))
      xerr = 2'd2;
    else if ((op == 3'd1 && (ar != br || ac != bc)) ||
             (op == 3'd3 && ac != br) ||
             (op == 3'd4 && (br != 3 || bc != 3 || ar < 3 || ac < 3)))
      xerr = 2'd3;
    if (xerr != 2'd0) begin
      xend = 2;
      return;
    end
    case (op)
      3'd0:    begin rows = ac;     cols = ar;     terms = 1;  end
      3'd3:    begin rows = ar;     cols = bc;     terms = ac; end
      3'd4:    begin rows = ar - 2; cols = ac - 2; terms = 9;  end
      default: begin rows = ar;     cols = ac;     terms = 1;  end
    endcase
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        v = 0;
        case (op)
          3'd0: v = ma[c][r];
          3'd1: v = ma[r][c] + mb[r][c];
          3'd2: v = ma[r][c] * sc;
          3'd3: for (int k = 0; k < ac; k++) v += ma[r][k] * mb[k][c];
          default:
            for (int u = 0; u < 3; u++)
              for (int q = 0; q < 3; q++) v += ma[r+u][c+q] * mb[u][q];
        endcase
        w.r = 3'(r);
        w.c = 3'(c);
        w.d = 20'(v);
        exp_q.push_back(w);
      end
    end
    xend = 2 + rows * cols * (3 * terms + 1);
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] sc,
                       input logic [2:0] ar, input logic [2:0] ac,
                       input logic [2:0] br, input logic [2:0] bc);
    op_sel     = op;
    scalar_val = sc;
    a_rows     = ar;
    a_cols     = ac;
    b_rows     = br;
    b_cols     = bc;
    start_op   = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] sc,
                        input logic [2:0] ar, input logic [2:0] ac,
                        input logic [2:0] br, input logic [2:0] bc,
                        input int extra);
    int         xend, rows, cols, s, c;
    logic [1:0] xerr;
    got_q.delete();
    build_model(op, sc, ar, ac, br, bc, xend, xerr, rows, cols);
    last_done   = -1;
    last_dones  = 0;
    last_err_at = -1;
    @(negedge clk);
    drive(op, sc, ar, ac, br, bc);
    s = cyc;
    for (int n = 0; n < xend + 4 && n < 3000; n++) begin
      @(negedge clk);
      c = cyc - s;
      if (c == 1) start_op = 1'b0;
      if (extra > 0 && c == extra) start_op = 1'b1;
      else if (extra > 0 && c == extra + 1) start_op = 1'b0;
      chk("busy", busy_flag, longint'(c <= xend));
      chk("done_flag", done_flag, longint'(xerr == 0 && c == xend));
      chk("error_flag", error_flag, longint'(xerr != 0 && c == xend));
      if (done_flag) begin
        last_dones++;
        last_done = c;
      end
      if (error_flag) begin
        last_err_at = c;
        chk("err_code", err_code, xerr);
      end
    end
    start_op = 1'b0;
    chk("pending_writes", exp_q.size(), 0);
    if (xerr == 0) begin
      chk("res_rows", res_rows, rows);
      chk("res_cols", res_cols, cols);
    end
  endtask

  task automatic chk_list(input string name, input int n,
                          input int l0, input int l1, input int l2,
                          input int l3, input int l4, input int l5);
    int lit[6];
    lit = '{l0, l1, l2, l3, l4, l5};
    chk({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk(name, got_q[i], lit[i]);
  endtask

  task automatic load_c();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  initial begin
    int         s, xend, rows, cols;
    logic [1:0] xerr;
    rst        = 1'b1;
    start_op   = 1'b0;
    op_sel     = '0;
    scalar_val = '0;
    a_rows     = '0;
    a_cols     = '0;
    b_rows     = '0;
    b_cols     = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_flag, 0);
    chk("rst_done", done_flag, 0);
    chk("rst_error", error_flag, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_res", {res_rows, res_cols, err_code}, 0);
    rst = 1'b0;

    // Transpose 2x3
    ma[0][0] = 1; ma[0][1] = 2; ma[0][2] = 3;
    ma[1][0] = 4; ma[1][1] = 5; ma[1][2] = 6;
    run_op(3'd0, 8'd0, 3'd2, 3'd3, 3'd0, 3'd0, 0);
    chk("T_done_cycle", last_done, 26);
    chk_list("T_data", 6, 1, 4, 2, 5, 3, 6);
    chk("T_res", {res_rows, res_cols}, {3'd3, 3'd2});

    // Matrix multiply 2x2
    load_c();
    run_op(3'd3, 8'd0, 3'd2, 3'd2, 3'd2, 3'd2, 0);
    chk("C_done_cycle", last_done, 30);
    chk_list("C_data", 4, 19, 22, 43, 50, 0, 0);

    // 3x3 convolution on 4x4
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ma[r][c] = 8'(4 * r + c + 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mb[r][c] = 8'd1;
    run_op(3'd4, 8'd0, 3'd4, 3'd4, 3'd3, 3'd3, 0);
    chk("J_done_cycle", last_done, 114);
    chk_list("J_data", 4, 54, 63, 90, 99, 0, 0);

    // Add with mismatched shapes
    run_op(3'd1, 8'd0, 3'd2, 3'd2, 3'd2, 3'd3, 0);
    chk("A_mism_err_cycle", last_err_at, 2);
    chk("A_mism_code", err_code, 3);
    chk("A_mism_writes", got_q.size(), 0);

    // Bad opcode
    run_op(3'd6, 8'd0, 3'd2, 3'd2, 3'd2, 3'd2, 0);
    chk("badop_code", err_code, 1);

    // Zero dimension for scalar multiply
    run_op(3'd2, 8'd3, 3'd0, 3'd2, 3'd0, 3'd0, 0);
    chk("zero_dim_code", err_code, 2);

    // Scalar multiply at max values, with a stray start at cycle 3
    ma[0][0] = 8'd255;
    run_op(3'd2, 8'd255, 3'd1, 3'd1, 3'd0, 3'd0, 3);
    chk_list("b_data", 1, 65025, 0, 0, 0, 0, 0);
    chk("b_done_count", last_dones, 1);
    chk("b_err_cleared", err_code, 0);

    // Reset in the middle of a matrix multiply
    load_c();
    got_q.delete();
    build_model(3'd3, 8'd0, 3'd2, 3'd2, 3'd2, 3'd2, xend, xerr, rows, cols);
    @(negedge clk);
    drive(3'd3, 8'd0, 3'd2, 3'd2, 3'd2, 3'd2);
    s = cyc;
    @(negedge clk);
    start_op = 1'b0;
    while (cyc - s < 10) @(negedge clk);
    chk("mid_busy", busy_flag, 1);
    chk("mid_writes", got_q.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("abort_busy", busy_flag, 0);
    chk("abort_strobes", {rd_en, wr_en, done_flag, error_flag}, 0);
    chk("abort_addr", {rd_row, rd_col, wr_row, wr_col}, 0);
    chk("abort_data", wr_data, 0);
    chk("abort_res", {res_rows, res_cols, err_code}, 0);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("post_abort_wr_en", wr_en, 0);
    end
    run_op(3'd3, 8'd0, 3'd2, 3'd2, 3'd2, 3'd2, 0);
    chk("restart_done_cycle", last_done, 30);
    chk_list("restart_data", 4, 19, 22, 43, 50, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_exec_unit.md
Name: op_exec_unit

Overview:
- Responder side of the operation handshake driven by the top-level control FSM.
- Accepts a one-cycle `start_op` pulse with `op_sel`, operand dimensions and a scalar, then validates the operands.
- Computes the result one element at a time through the storage read port and writes each element through the result write port.
- Reports status on `busy_flag`, `done_flag` and `error_flag`.
- Supported ops: transpose, add, scalar multiply, matrix multiply, 3x3 convolution.

Parameters:
- DATA_W, 8: operand element width, unsigned.
- ACC_W, 20: result element width. Must be >= 2*DATA_W+4 so that no result can overflow.
- MAX_DIM, 5: maximum rows and columns per matrix.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start_op  in  1  one-cycle start request
- op_sel  in  3  000 T, 001 A (add), 010 b (scalar mult), 011 C (matmul), 100 J (conv)
- scalar_val  in  DATA_W  scalar for op b
- a_rows, a_cols  in  3 each  dimensions of operand A
- b_rows, b_cols  in  3 each  dimensions of operand B
- rd_en  out  1  storage read strobe
- rd_sel  out  1  0 = operand A, 1 = operand B
- rd_row, rd_col  out  3 each  read coordinates
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  result element write strobe
- wr_row, wr_col  out  3 each  result coordinates
- wr_data  out  ACC_W  result element
- res_rows, res_cols  out  3 each  result dimensions
- busy_flag  out  1  high in every state except IDLE
- done_flag  out  1  one-cycle completion pulse
- error_flag  out  1  one-cycle error pulse
- err_code  out  2  01 bad op, 10 dimension out of range, 11 dimension mismatch

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; FSM to IDLE.
- Reset mid-operation: abort immediately; no further rd_en or wr_en.
- States: IDLE, CHECK, RD_A, RD_B, MAC, WR, DONE, ERR.
- IDLE:
  - start_op=1 registers op_sel, scalar_val and all four dimensions; goes to CHECK.
  - err_code is cleared to 0 on acceptance.
  - start_op in any other state is ignored.
- CHECK, checks in priority order (all dimensions 1..MAX_DIM):
  - op_sel > 100 -> err 01.
  - Any used dimension is 0 or > MAX_DIM -> err 10. T and b use A only; A, C and J use A and B.
  - Mismatch -> err 11:
    - A requires a_rows==b_rows and a_cols==b_cols.
    - C requires a_cols==b_rows.
    - J requires b_rows==b_cols==3 and a_rows>=3 and a_cols>=3.
  - On error: go to ERR.
  - Otherwise: load res_rows/res_cols and go to RD_A. Result dimensions:
    - T: a_cols x a_rows.
    - A, b: a_rows x a_cols.
    - C: a_rows x b_cols.
    - J: (a_rows-2) x (a_cols-2).
  - res_rows/res_cols are held until the next successful CHECK.
- ERR: error_flag=1 for this single cycle, err_code is held, then IDLE. No wr_en is ever issued.
- Element loop:
  - Output (i,j) is walked row-major, (0,0) first.
  - Each output has terms: 1 for T, A and b; a_cols for C; 9 for J, with (u,v) row-major.
  - The accumulator is cleared at the start of each output element.
- RD_A: rd_en=1, rd_sel=0. Read address per op:
  - T: A(j,i).
  - A, b: A(i,j).
  - C: A(i,k).
  - J: A(i+u, j+v).
- RD_B: latch a_reg from rd_data. For A, C and J also issue rd_en=1, rd_sel=1 at:
  - A: B(i,j).
  - C: B(k,j).
  - J: B(u,v).
- MAC: latch b_reg where used, then update the accumulator:
  - T: acc = a.
  - b: acc = a*scalar.
  - A: acc = a+b.
  - C, J: acc += a*b.
  - Next state: RD_A if more terms remain, else WR.
- WR: wr_en=1 with wr_row=i, wr_col=j, wr_data=acc. Next state: RD_A if more elements remain, else DONE.
- DONE: done_flag=1 for one cycle, then IDLE.
- Timing:
  - Cost per element: 3*terms+1 cycles.
  - Taking the start_op cycle as cycle 0, CHECK is cycle 1.
  - done_flag rises at cycle 2 + sum over elements of (3*terms+1).
  - error_flag rises at cycle 2.
- Arithmetic: unsigned and zero-extended to ACC_W. Defaults cannot overflow. Outside the active read cycles rd_en=0 and rd_row/rd_col hold their values.

Test Plan:
- T, A=2x3 [[1,2,3],[4,5,6]]:
  - res 3x2.
  - Writes (0,0)=1, (0,1)=4, (1,0)=2, (1,1)=5, (2,0)=3, (2,1)=6.
  - done_flag at cycle 26; busy_flag high cycles 1..26.
- C, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - Writes 19, 22, 43, 50 in row-major order.
  - done_flag at cycle 30.
- J, A 4x4 with A(r,c)=4r+c+1, B 3x3 all ones:
  - res 2x2 = 54, 63, 90, 99.
  - done_flag at cycle 114.
- Error cases:
  - A with a=2x2, b=2x3 -> error_flag pulse at cycle 2, err_code=11, no wr_en.
  - op_sel=110 -> err_code=01.
  - b with a_rows=0 -> err_code=10.
- b, A=[[255]], scalar 255:
  - wr_data=65025.
  - A second start_op at cycle 3 is ignored: exactly one write, one done_flag.
- Reset mid-operation: assert rst during a C operation at cycle 10.
  - The next cycle shows all outputs 0 with busy_flag=0.
  - No writes follow.
  - A fresh start_op then completes normally.
